// File: rtl/button_gesture_pkg.sv
// Shared types and default timing constants for the button gesture classifier.
// Timing constants are counted in divider ticks, not in clk cycles.
package button_gesture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS1 = 3'd1,
        ST_LONG   = 3'd2,
        ST_WAIT2  = 3'd3,
        ST_PRESS2 = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        EV_NONE   = 3'd0,
        EV_SHORT  = 3'd1,
        EV_DOUBLE = 3'd2,
        EV_LONG   = 3'd3,
        EV_REPEAT = 3'd4
    } event_e;

    localparam int DEF_LONG_TICKS   = 64;
    localparam int DEF_DOUBLE_TICKS = 16;
    localparam int DEF_REPEAT_TICKS = 8;
    localparam int DEF_CW           = 8;

endpackage

// File: rtl/button_gesture_if.sv
// Button input / gesture event bundle. The master drives the button level and
// the divider bit; the slave (the classifier) drives the event pulses and busy.
interface button_gesture_if;

    logic btn_i;
    logic sclk_i;
    logic short_press_o;
    logic double_press_o;
    logic long_press_o;
    logic repeat_o;
    logic busy_o;

    modport master (
        output btn_i,
        output sclk_i,
        input  short_press_o,
        input  double_press_o,
        input  long_press_o,
        input  repeat_o,
        input  busy_o
    );

    modport slave (
        input  btn_i,
        input  sclk_i,
        output short_press_o,
        output double_press_o,
        output long_press_o,
        output repeat_o,
        output busy_o
    );

endinterface

// File: rtl/button_gesture_tick_edge.sv
// Rising-edge strobe for a clk-synchronous level. The history register resets
// to 1 so a level already high during reset produces no strobe afterwards.
module button_gesture_tick_edge (
    input  logic clk,
    input  logic rst,
    input  logic level_i,
    output logic strobe_o
);

    logic level_q;

    // Previous-cycle copy of the level.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= 1'b1;
        end else begin
            level_q <= level_i;
        end
    end

    assign strobe_o = level_i & ~level_q;

endmodule

// File: rtl/button_gesture.sv
// Classifies a debounced button level into short, double, long and repeat
// events, timing every gesture window in divider ticks.
module button_gesture
    import button_gesture_pkg::*;
#(
    parameter int LONG_TICKS   = DEF_LONG_TICKS,
    parameter int DOUBLE_TICKS = DEF_DOUBLE_TICKS,
    parameter int REPEAT_TICKS = DEF_REPEAT_TICKS,
    parameter int CW           = DEF_CW
) (
    input  logic             clk,
    input  logic             rst,
    button_gesture_if.slave  bus
);

    localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_TICKS - 1);
    localparam logic [CW-1:0] DOUBLE_LAST = CW'(DOUBLE_TICKS - 1);
    localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_TICKS - 1);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO    = CW'(0);

    logic          tick_s;
    logic          rise_s;
    state_e        state_q;
    state_e        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    event_e        ev_d;
    logic          short_q;
    logic          double_q;
    logic          long_q;
    logic          repeat_q;
    logic          busy_q;

    button_gesture_tick_edge u_sclk_edge (
        .clk      (clk),
        .rst      (rst),
        .level_i  (bus.sclk_i),
        .strobe_o (tick_s)
    );

    button_gesture_tick_edge u_btn_edge (
        .clk      (clk),
        .rst      (rst),
        .level_i  (bus.btn_i),
        .strobe_o (rise_s)
    );

    // Next state, tick counter and event selection; a btn change beats a tick.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ev_d    = EV_NONE;
        case (state_q)
            ST_IDLE: begin
                if (rise_s) begin
                    state_d = ST_PRESS1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRESS1: begin
                if (!bus.btn_i) begin
                    state_d = ST_WAIT2;
                end else if (tick_s) begin
                    if (cnt_q == LONG_LAST) begin
                        ev_d    = EV_LONG;
                        state_d = ST_LONG;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_LONG: begin
                if (!bus.btn_i) begin
                    state_d = ST_IDLE;
                end else if (tick_s) begin
                    if (cnt_q == REPEAT_LAST) begin
                        ev_d  = EV_REPEAT;
                        cnt_d = CNT_ZERO;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_WAIT2: begin
                if (bus.btn_i) begin
                    state_d = ST_PRESS2;
                end else if (tick_s) begin
                    if (cnt_q == DOUBLE_LAST) begin
                        ev_d    = EV_SHORT;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_PRESS2: begin
                if (!bus.btn_i) begin
                    ev_d    = EV_DOUBLE;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_PRESS2;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
        if (state_d != state_q) begin
            cnt_d = CNT_ZERO;
        end else begin
            cnt_d = cnt_d;
        end
    end

    // State, counter and registered event/busy outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= CNT_ZERO;
            short_q  <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            short_q  <= (ev_d == EV_SHORT);
            double_q <= (ev_d == EV_DOUBLE);
            long_q   <= (ev_d == EV_LONG);
            repeat_q <= (ev_d == EV_REPEAT);
            busy_q   <= (state_d != ST_IDLE);
        end
    end

    assign bus.short_press_o  = short_q;
    assign bus.double_press_o = double_q;
    assign bus.long_press_o   = long_q;
    assign bus.repeat_o       = repeat_q;
    assign bus.busy_o         = busy_q;

endmodule

// File: tb/tb_button_gesture.sv
// Scoreboard bench for button_gesture: a tick-counting gesture model predicts
// the event and busy level of every cycle; a monitor compares the DUT outputs.
module tb_button_gesture;

    localparam int LT = 8;
    localparam int DT = 4;
    localparam int RT = 3;

    localparam int E_NONE   = 0;
    localparam int E_SHORT  = 1;
    localparam int E_DOUBLE = 2;
    localparam int E_LONG   = 3;
    localparam int E_REPEAT = 4;
    localparam int E_MULTI  = 9;

    typedef struct {
        int cyc;
        bit busy;
        int ev;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q[$];

    // gesture model: measured in whole ticks since press / since release
    bit m_active, m_down, m_btn_prev, m_sclk_prev;
    int m_presses, m_held, m_gap;

    // divider bit generator
    bit cur_s;
    bit s_run;
    int s_cnt;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    button_gesture_if bus ();

    button_gesture #(
        .LONG_TICKS   (LT),
        .DOUBLE_TICKS (DT),
        .REPEAT_TICKS (RT),
        .CW           (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic bit next_s();
        if (s_run) return (((s_cnt + 1) >> 1) & 1) != 0;
        return cur_s;
    endfunction

    function automatic bit will_tick();
        return next_s() && !m_sclk_prev;
    endfunction

    task automatic model(input bit b, input bit s, input bit r, output int ev);
        bit tk;
        bit rs;
        ev = E_NONE;
        tk = s && !m_sclk_prev;
        rs = b && !m_btn_prev;
        if (r) begin
            m_active    = 1'b0;
            m_btn_prev  = 1'b1;
            m_sclk_prev = 1'b1;
        end else begin
            if (!m_active) begin
                if (rs) begin
                    m_active  = 1'b1;
                    m_presses = 1;
                    m_down    = 1'b1;
                    m_held    = 0;
                    m_gap     = 0;
                end
            end else if (m_presses == 1 && m_down) begin
                if (!b) begin
                    if (m_held >= LT) m_active = 1'b0;
                    else begin
                        m_down = 1'b0;
                        m_gap  = 0;
                    end
                end else if (tk) begin
                    m_held++;
                    if (m_held == LT) ev = E_LONG;
                    else if (m_held > LT && ((m_held - LT) % RT) == 0) ev = E_REPEAT;
                end
            end else if (m_presses == 1) begin
                if (b) begin
                    m_presses = 2;
                    m_down    = 1'b1;
                end else if (tk) begin
                    m_gap++;
                    if (m_gap == DT) begin
                        ev       = E_SHORT;
                        m_active = 1'b0;
                    end
                end
            end else begin
                if (!b) begin
                    ev       = E_DOUBLE;
                    m_active = 1'b0;
                end
            end
            m_btn_prev  = b;
            m_sclk_prev = s;
        end
    endtask

    task automatic step(input bit b, input bit r);
        int   ev;
        exp_t e;
        if (s_run) begin
            s_cnt++;
            cur_s = ((s_cnt >> 1) & 1) != 0;
        end
        bus.btn_i  = b;
        bus.sclk_i = cur_s;
        rst        = r;
        model(b, cur_s, r, ev);
        e.cyc  = cyc + 1;
        e.busy = m_active;
        e.ev   = ev;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Steps with b_pre until the next tick cycle, which is driven with b_on/r_on.
    task automatic tick_step(input bit b_pre, input bit b_on, input bit r_on);
        for (int k = 0; k < 8 && !will_tick(); k++) step(b_pre, 1'b0);
        step(b_on, r_on);
    endtask

    task automatic hold(input bit b, input int n);
        for (int k = 0; k < n; k++) tick_step(b, b, 1'b0);
    endtask

    initial begin
        bus.btn_i   = 1'b0;
        bus.sclk_i  = 1'b0;
        rst         = 1'b1;
        s_run       = 1'b1;
        s_cnt       = 0;
        cur_s       = 1'b0;
        m_active    = 1'b0;
        m_down      = 1'b0;
        m_presses   = 0;
        m_held      = 0;
        m_gap       = 0;
        m_btn_prev  = 1'b1;
        m_sclk_prev = 1'b1;

        fork
            forever begin
                exp_t e;
                int   obs;
                int   nh;
                @(negedge clk);
                while (q.size() > 0 && q[0].cyc < cyc) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL missed_entry: monitor at cycle %0d, required entry for cycle %0d", cyc, q[0].cyc);
                    void'(q.pop_front());
                end
                if (q.size() > 0 && q[0].cyc == cyc) begin
                    e   = q.pop_front();
                    nh  = 0;
                    obs = E_NONE;
                    if (bus.short_press_o === 1'b1)  begin nh++; obs = E_SHORT;  end
                    if (bus.double_press_o === 1'b1) begin nh++; obs = E_DOUBLE; end
                    if (bus.long_press_o === 1'b1)   begin nh++; obs = E_LONG;   end
                    if (bus.repeat_o === 1'b1)       begin nh++; obs = E_REPEAT; end
                    if (nh > 1) obs = E_MULTI;
                    n_checks++;
                    if (obs != e.ev) begin
                        n_errors++;
                        $display("FAIL event @%0d: got code %0d, required %0d (1=short 2=double 3=long 4=repeat 9=multi)", cyc, obs, e.ev);
                    end
                    n_checks++;
                    if (bus.busy_o !== e.busy) begin
                        n_errors++;
                        $display("FAIL busy @%0d: got %b, required %b", cyc, bus.busy_o, e.busy);
                    end
                end
            end
        join_none

        repeat (3) step(1'b0, 1'b1);

        // single press -> short
        hold(1'b0, 2); hold(1'b1, 3); hold(1'b0, 10);
        // double press
        hold(1'b1, 2); hold(1'b0, 2); hold(1'b1, 2); hold(1'b0, 6);
        // long press with repeats
        hold(1'b1, 20); hold(1'b0, 4);
        // release on the long threshold tick, press on the short timeout tick
        hold(1'b1, 7); tick_step(1'b1, 1'b0, 1'b0);
        hold(1'b0, 3); tick_step(1'b0, 1'b1, 1'b0);
        hold(1'b1, 2); hold(1'b0, 6);
        // button held through reset is ignored until pressed again
        repeat (4) step(1'b1, 1'b1);
        hold(1'b1, 3); hold(1'b0, 2); hold(1'b1, 2); hold(1'b0, 6);
        // reset on the cycle a long press is due
        hold(1'b1, 7); tick_step(1'b1, 1'b1, 1'b1); step(1'b1, 1'b0); hold(1'b0, 2);
        // divider stuck: btn edges still move the gesture, no timeouts
        s_run = 1'b0;
        repeat (30) step(1'b1, 1'b0);
        repeat (40) step(1'b0, 1'b0);
        s_run = 1'b1;
        hold(1'b0, 6);

        // randomized segments
        for (int seg = 0; seg < 150; seg++) begin
            int len;
            bit b;
            bit r;
            s_run = ($urandom_range(0, 9) != 0);
            len   = $urandom_range(1, 60);
            b     = $urandom_range(0, 1) != 0;
            r     = ($urandom_range(0, 30) == 0);
            step(b, r);
            for (int k = 1; k < len; k++) step(b, 1'b0);
        end
        s_run = 1'b1;
        hold(1'b0, 10);

        for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d entries left, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
